// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: types and defaults shared by the HyperBus controller slice.
//   hyper_wr_state_e : write-data transmitter states
//   BURST_W_DEF      : default width of the burst word counter
//   LAT_W_DEF        : default width of the initial-latency counter
package hyperbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATENCY = 2'd1,
    ST_DATA    = 2'd2,
    ST_DONE    = 2'd3
  } hyper_wr_state_e;

  localparam int unsigned BURST_W_DEF = 16;
  localparam int unsigned LAT_W_DEF   = 4;

endpackage

// File: rtl/ddr_out_pair.sv
// ddr_out_pair: registered rise/fall byte pair, RWDS mask and output enable
// feeding the DDR output cells. It is the transmit mirror of the DDR input
// capture.
//   clk0        : clock
//   rst_ni      : synchronous active-low reset, clears every register
//   clr_i       : synchronous clear (abort), overrides ld_i
//   ld_i        : load enable; when low the pair idles at zero with OE low
//   data_i      : [15:8] rise byte, [7:0] fall byte
//   strb_i      : [1] rise byte enable, [0] fall byte enable
//   dq_rise_o / dq_fall_o     : registered data bytes
//   rwds_rise_o / rwds_fall_o : registered mask bits (1 = masked)
//   oe_o        : registered output enable for DQ and RWDS
module ddr_out_pair (
  input  logic        clk0,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  strb_i,
  output logic [7:0]  dq_rise_o,
  output logic [7:0]  dq_fall_o,
  output logic        rwds_rise_o,
  output logic        rwds_fall_o,
  output logic        oe_o
);

  logic [7:0] dq_rise_p1;
  logic [7:0] dq_fall_p1;
  logic       rwds_rise_p1;
  logic       rwds_fall_p1;
  logic       vld_p1;

  // Stage p0 -> p1: one beat per cycle, zeroed whenever no word is loaded
  // so the pins never show stale data while OE is low.
  always_ff @(posedge clk0) begin
    if (!rst_ni || clr_i || !ld_i) begin
      dq_rise_p1   <= 8'h00;
      dq_fall_p1   <= 8'h00;
      rwds_rise_p1 <= 1'b0;
      rwds_fall_p1 <= 1'b0;
      vld_p1       <= 1'b0;
    end else begin
      dq_rise_p1   <= data_i[15:8];
      dq_fall_p1   <= data_i[7:0];
      rwds_rise_p1 <= ~strb_i[1];
      rwds_fall_p1 <= ~strb_i[0];
      vld_p1       <= 1'b1;
    end
  end

  assign dq_rise_o   = dq_rise_p1;
  assign dq_fall_o   = dq_fall_p1;
  assign rwds_rise_o = rwds_rise_p1;
  assign rwds_fall_o = rwds_fall_p1;
  assign oe_o        = vld_p1;

endmodule

// File: rtl/hyper_write_tx.sv
// hyper_write_tx: HyperBus write-data transmitter. Accepts 16-bit words with
// byte strobes over valid/ready, waits the programmed initial latency, then
// drives one DDR beat per cycle. Counts the burst, flags underrun and pulses
// completion.
//   clk0, rst_ni           : clock, synchronous active-low reset
//   start_i                : start pulse (IDLE only), samples burst_len_i/latency_i
//   burst_len_i            : words in the burst (0 = go straight to DONE)
//   latency_i              : cycles between start and DATA
//   abort_i                : cancel everything, return to IDLE, no done pulse
//   data_i, strb_i         : write word and byte enables
//   valid_i, ready_o       : word handshake
//   dq_rise_o, dq_fall_o   : DDR byte pair (registered)
//   rwds_rise_o, rwds_fall_o : RWDS byte mask (1 = masked)
//   dq_oe_o, rwds_oe_o     : output enables
//   busy_o                 : state is not IDLE
//   done_o, underrun_o     : completion pulse, underrun qualifier
module hyper_write_tx
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_W = BURST_W_DEF,
  parameter int unsigned LAT_W   = LAT_W_DEF
) (
  input  logic               clk0,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [LAT_W-1:0]   latency_i,
  input  logic               abort_i,
  input  logic [15:0]        data_i,
  input  logic [1:0]         strb_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [7:0]         dq_rise_o,
  output logic [7:0]         dq_fall_o,
  output logic               rwds_rise_o,
  output logic               rwds_fall_o,
  output logic               dq_oe_o,
  output logic               rwds_oe_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               underrun_o
);

  hyper_wr_state_e    state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               under_q, under_d;
  logic               hs;
  logic               oe;

  always_ff @(posedge clk0) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      lat_q   <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      under_q <= under_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    lat_d      = lat_q;
    under_d    = under_q;
    ready_o    = 1'b0;
    hs         = 1'b0;
    done_o     = 1'b0;
    underrun_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d = burst_len_i;
          lat_d = latency_i;
          if (burst_len_i == '0)    state_d = ST_DONE;
          else if (latency_i == '0) state_d = ST_DATA;
          else                      state_d = ST_LATENCY;
        end
      end
      ST_LATENCY: begin
        // Decrement-only; the guard keeps the counter from wrapping.
        if (lat_q != '0) lat_d = lat_q - 1'b1;
        if (lat_q == LAT_W'(1)) state_d = ST_DATA;
      end
      ST_DATA: begin
        ready_o = ~abort_i;
        if (valid_i) begin
          hs = 1'b1;
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) state_d = ST_DONE;
        end else begin
          // A HyperBus write cannot stall mid-burst: a gap ends the burst.
          under_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o     = 1'b1;
        underrun_o = under_q;
        under_d    = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over start, handshake, completion and every transition.
    if (abort_i) begin
      state_d    = ST_IDLE;
      under_d    = 1'b0;
      hs         = 1'b0;
      done_o     = 1'b0;
      underrun_o = 1'b0;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

  ddr_out_pair u_out (
    .clk0        (clk0),
    .rst_ni      (rst_ni),
    .clr_i       (abort_i),
    .ld_i        (hs),
    .data_i      (data_i),
    .strb_i      (strb_i),
    .dq_rise_o   (dq_rise_o),
    .dq_fall_o   (dq_fall_o),
    .rwds_rise_o (rwds_rise_o),
    .rwds_fall_o (rwds_fall_o),
    .oe_o        (oe)
  );

  assign dq_oe_o   = oe;
  assign rwds_oe_o = oe;

endmodule

// File: tb/tb_hyper_write_tx.sv
module tb_hyper_write_tx;

  logic        clk0 = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] burst_len_i;
  logic [3:0]  latency_i;
  logic        abort_i;
  logic [15:0] data_i;
  logic [1:0]  strb_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  dq_rise_o, dq_fall_o;
  logic        rwds_rise_o, rwds_fall_o;
  logic        dq_oe_o, rwds_oe_o;
  logic        busy_o, done_o, underrun_o;

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  hyper_write_tx #(.BURST_W(16), .LAT_W(4)) dut (
    .clk0        (clk0),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .latency_i   (latency_i),
    .abort_i     (abort_i),
    .data_i      (data_i),
    .strb_i      (strb_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dq_rise_o   (dq_rise_o),
    .dq_fall_o   (dq_fall_o),
    .rwds_rise_o (rwds_rise_o),
    .rwds_fall_o (rwds_fall_o),
    .dq_oe_o     (dq_oe_o),
    .rwds_oe_o   (rwds_oe_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .underrun_o  (underrun_o)
  );

  // Observed output bundle: {ready,busy,done,underrun,dq_oe,rwds_oe,rwds_rise,rwds_fall,dq_rise,dq_fall}
  function automatic logic [23:0] obs();
    return {ready_o, busy_o, done_o, underrun_o, dq_oe_o, rwds_oe_o,
            rwds_rise_o, rwds_fall_o, dq_rise_o, dq_fall_o};
  endfunction

  function automatic logic [23:0] ev(input logic rdy, input logic bsy, input logic dn,
                                     input logic ur, input logic oe, input logic rr,
                                     input logic rf, input logic [7:0] r, input logic [7:0] f);
    return {rdy, bsy, dn, ur, oe, oe, rr, rf, r, f};
  endfunction

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled
  // 3 units later, well clear of both clock edges.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] exp);
    logic [23:0] o;
    #3;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed %06h expected %06h", tag, o, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] len, input logic [3:0] lat,
                       input logic vld, input logic [15:0] d, input logic [1:0] s,
                       input logic ab);
    start_i = st; burst_len_i = len; latency_i = lat;
    valid_i = vld; data_i = d; strb_i = s; abort_i = ab;
  endtask

  // L=3, N=4, valid held high: ready cycles 4..7, OE 5..8, done cycle 8.
  task automatic run_basic(input string tag);
    logic [15:0] w [4];
    w[0] = 16'hA1B2; w[1] = 16'hC3D4; w[2] = 16'hE5F6; w[3] = 16'h0718;
    drive(1'b1, 16'd4, 4'd3, 1'b1, w[0], 2'b11, 1'b0);
    chk({tag, "_c0"}, ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("%s_lat_c%0d", tag, c), ev(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
      tick();
    end
    data_i = w[0];
    chk({tag, "_c4"}, ev(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    for (int c = 5; c <= 7; c++) begin
      data_i = w[c-4];
      chk($sformatf("%s_c%0d", tag, c), ev(1, 1, 0, 0, 1, 0, 0, w[c-5][15:8], w[c-5][7:0]));
      tick();
    end
    valid_i = 1'b0;
    chk({tag, "_c8_done"}, ev(0, 1, 1, 0, 1, 0, 0, 8'h07, 8'h18));
    tick();
    chk({tag, "_c9_idle"}, ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 16'd0, 4'd0, 1'b0, 16'h0000, 2'b00, 1'b0);
    tick(); tick();
    chk("reset_state", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic burst
    run_basic("basic");
    tick();

    // Masking, zero latency: strobes 10 then 01
    drive(1'b1, 16'd2, 4'd0, 1'b1, 16'h1234, 2'b10, 1'b0);
    chk("mask_c0", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b0;
    chk("mask_c1_data", ev(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    data_i = 16'h5678; strb_i = 2'b01;
    chk("mask_c2", ev(1, 1, 0, 0, 1, 0, 1, 8'h12, 8'h34));
    tick();
    valid_i = 1'b0;
    chk("mask_c3_done", ev(0, 1, 1, 0, 1, 1, 0, 8'h56, 8'h78));
    tick();
    chk("mask_c4_idle", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();

    // Underrun: L=1, N=5, valid dropped after 2 words; start in LATENCY ignored
    drive(1'b1, 16'd5, 4'd1, 1'b1, 16'h1111, 2'b11, 1'b0);
    chk("ur_c0", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b1; burst_len_i = 16'd1; latency_i = 4'd5;
    chk("ur_c1_lat", ev(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b0;
    chk("ur_c2_data", ev(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    data_i = 16'h2222;
    chk("ur_c3", ev(1, 1, 0, 0, 1, 0, 0, 8'h11, 8'h11));
    tick();
    valid_i = 1'b0;
    chk("ur_c4_gap", ev(1, 1, 0, 0, 1, 0, 0, 8'h22, 8'h22));
    tick();
    chk("ur_c5_done", ev(0, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00));
    tick();
    chk("ur_c6_idle", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();

    // Abort in third DATA cycle with valid high
    drive(1'b1, 16'd8, 4'd0, 1'b1, 16'hAAAA, 2'b11, 1'b0);
    chk("ab_c0", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b0;
    chk("ab_c1", ev(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    data_i = 16'hBBBB;
    chk("ab_c2", ev(1, 1, 0, 0, 1, 0, 0, 8'hAA, 8'hAA));
    tick();
    data_i = 16'hCCCC; abort_i = 1'b1;
    chk("ab_c3_abort", ev(0, 1, 0, 0, 1, 0, 0, 8'hBB, 8'hBB));
    tick();
    abort_i = 1'b0; valid_i = 1'b0;
    chk("ab_c4_idle", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    chk("ab_c5_idle", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();

    // Zero-length burst, then back-to-back start in first IDLE cycle
    drive(1'b1, 16'd0, 4'd3, 1'b0, 16'h0000, 2'b11, 1'b0);
    chk("zl_c0", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b0;
    chk("zl_c1_done", ev(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    drive(1'b1, 16'd1, 4'd0, 1'b1, 16'h9ABC, 2'b11, 1'b0);
    chk("b2b_c0", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    start_i = 1'b0;
    chk("b2b_c1_data", ev(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    valid_i = 1'b0;
    chk("b2b_c2_done", ev(0, 1, 1, 0, 1, 0, 0, 8'h9A, 8'hBC));
    tick();
    chk("b2b_c3_idle", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();

    // Reset for one cycle during DATA
    drive(1'b1, 16'd4, 4'd0, 1'b1, 16'hDEAD, 2'b11, 1'b0);
    tick();
    start_i = 1'b0;
    chk("rst_c1_data", ev(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    rst_ni = 1'b0;
    chk("rst_c2", ev(1, 1, 0, 0, 1, 0, 0, 8'hDE, 8'hAD));
    tick();
    rst_ni = 1'b1; valid_i = 1'b0;
    chk("rst_c3_cleared", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    chk("rst_c4_idle", ev(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    run_basic("post_rst");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyper_write_tx.md
# hyper_write_tx

HyperBus write-data transmitter: the outbound counterpart of the RWDS-clocked read capture path. It takes 16-bit write words with byte strobes from the controller's TX FIFO over valid/ready in the `clk0` domain. It waits a programmed initial latency, then emits one DDR beat per cycle as registered rise/fall byte pairs plus RWDS byte-mask bits for the DDR output cells. It counts the burst, flags data underrun, and signals completion to the transaction FSM.

## Interface
Parameters:
- `BURST_W`, 16: width of the burst word counter.
- `LAT_W`, 4: width of the initial-latency count.

Ports:
- `clk0` in 1: single clock. One clock; reset is synchronous and active-low.
- `rst_ni` in 1: synchronous active-low reset.
- `start_i` in 1: pulse that starts a write burst. Honoured only in IDLE.
- `burst_len_i` in BURST_W: number of 16-bit words in the burst, sampled with `start_i`.
- `latency_i` in LAT_W: `clk0` cycles between start and the DATA phase, sampled with `start_i`.
- `abort_i` in 1: cancels any activity and returns to IDLE.
- `data_i` in 16: write word. `[15:8]` goes on the rising edge, `[7:0]` on the falling edge.
- `strb_i` in 2: byte enables. `[1]` is the rise byte, `[0]` is the fall byte.
- `valid_i` in 1: word valid.
- `ready_o` out 1: word accepted when `valid_i && ready_o`.
- `dq_rise_o` out 8, `dq_fall_o` out 8: DDR data byte pair.
- `rwds_rise_o` out 1, `rwds_fall_o` out 1: RWDS mask (1 = byte masked, equal to `~strb`).
- `dq_oe_o` out 1, `rwds_oe_o` out 1: output enables, asserted together.
- `busy_o` out 1: high whenever the state is not IDLE.
- `done_o` out 1: single-cycle completion pulse.
- `underrun_o` out 1: single-cycle pulse, coincident with `done_o`, when the burst ended by underrun.

## Operation
- States: IDLE, LATENCY, DATA, DONE. The state enum lives in the package.
- IDLE:
  - `start_i` latches the length and latency into `rem_q` and `lat_q`.
  - Next state: DONE if `burst_len_i == 0`; DATA if `latency_i == 0`; otherwise LATENCY.
- LATENCY: `lat_q` decrements each cycle. When `lat_q == 1`, the next state is DATA.
- DATA:
  - `ready_o = 1` (combinational from state, gated by `~abort_i`).
  - On handshake: the output registers load `data_i[15:8]`, `data_i[7:0]`, `~strb_i[1]`, `~strb_i[0]` and set both OE bits to 1. `rem_q` decrements.
  - When the handshake consumes the last word (`rem_q == 1`), the next state is DONE.
  - `valid_i == 0` in DATA is an underrun, because HyperBus writes cannot pause. The next state is DONE with the underrun flag set, and no further beats are sent.
- Output registers when no handshake occurs: data and mask go to 0, and both OE bits go to 0.
- DONE: `done_o = 1` for one cycle, plus `underrun_o` if the flag is set. Next state is IDLE and the flag clears.
- `start_i` in any non-IDLE state is ignored.
- `abort_i` overrides `start_i`, the handshake, and every transition:
  - next state is IDLE;
  - OE and data registers clear;
  - no `done_o` or `underrun_o` is generated.
- Reset: every output is 0, the state is IDLE, and all counters are 0.
- Arithmetic: `rem_q` is BURST_W bits and `lat_q` is LAT_W bits. Both are decrement-only and never wrap. The maximum burst is 2^BURST_W-1 words.

## Timing
- Start accepted at cycle 0 with latency L ≥ 1:
  - LATENCY occupies cycles 1..L.
  - DATA begins at cycle L+1, which is the first cycle `ready_o` is high.
- With L = 0, DATA begins at cycle 1.
- Output latency: a word accepted in cycle t appears on the `dq_*`, `rwds_*` and `*_oe_o` pins in cycle t+1.
- Full burst of N words with no underrun:
  - handshakes occur in cycles L+1..L+N;
  - OE is high in cycles L+2..L+N+1;
  - DONE and `done_o` fall in cycle L+N+1;
  - IDLE is reached in cycle L+N+2, and a new `start_i` is accepted there.
- `burst_len_i == 0`: DONE in cycle 1, IDLE in cycle 2. OE is never asserted.
- Underrun in DATA cycle k:
  - no beat in cycle k+1, so OE is low there;
  - DONE, `done_o` and `underrun_o` occur in cycle k+1.
- `rst_ni` low mid-burst: all outputs are 0 on the next edge and the burst is dropped.

## Structure
- Shared package `hyperbus_pkg` holds:
  - `hyper_wr_state_e` (IDLE, LATENCY, DATA, DONE);
  - the default `BURST_W` and `LAT_W` constants.
- The natural sub-module is `ddr_out_pair`, the mirror of the DDR input capture. It holds the registered rise/fall data, mask and OE, with synchronous clear and a load enable. The FSM and counters stay in the top module.

## Test plan
- **Basic burst:** L=3, N=4, `valid_i` held high, words 0xA1B2/0xC3D4/0xE5F6/0x0718, strobes 2'b11 → `ready_o` high in cycles 4..7. OE high in cycles 5..8, with `dq_rise/fall` = A1/B2, C3/D4, E5/F6, 07/18 and masks 0. `done_o` in cycle 8 only. `busy_o` in cycles 1..8.
- **Masking and zero latency:** L=0, N=2, strobes 2'b10 then 2'b01 → `rwds_rise/fall` = 0/1, then 1/0. DATA begins in cycle 1.
- **Underrun:** L=1, N=5, `valid_i` dropped after 2 words → exactly 2 OE beats, then `done_o` and `underrun_o` pulse together one cycle after the missing beat. `ready_o` is 0 afterwards.
- **Abort:** N=8, `abort_i` asserted in the third DATA cycle with `valid_i` high → that word is not consumed, OE goes low the next cycle, state returns to IDLE, and `done_o` is never asserted.
- **Edge cases:** `burst_len_i=0` → `done_o` in cycle 1 with no OE. `start_i` asserted during a burst → ignored. Back-to-back `start_i` asserted in the first IDLE cycle after DONE → accepted.
- **Reset mid-burst:** `rst_ni` low for one cycle during DATA → all outputs are 0 the next cycle. A subsequent burst behaves as in the basic-burst test.
